mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, meaning: wait cycles between request acceptance and Done; legal range 0..15.
REQ-002 Parameter ADDR_BITS, default 9, meaning: implemented word-address width, giving 512 words.
REQ-003 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset; asynchronous, active-high.
REQ-005 MAR  input  32  word address from the datapath MAR.
REQ-006 Read  input  1  read request; sampled in IDLE only.
REQ-007 Write  input  1  write request; sampled in IDLE only.
REQ-008 MDRdata  input  32  write data from the datapath MDR.
REQ-009 Mdatain  output  32  read data toward the datapath MDR input mux.
REQ-010 Done  output  1  one-cycle completion pulse for an accepted request.
REQ-011 Busy  output  1  high from request acceptance through the Done cycle inclusive.
REQ-012 Err  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-013 FSM states shall be IDLE, WAIT and RESP.
REQ-014 IDLE with exactly one of Read or Write high shall latch MAR, MDRdata and the operation, then go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-015 WAIT shall count down the latched wait count and go to RESP on the edge where the count reaches 0.
REQ-016 RESP shall last one cycle with Done=1, then return to IDLE.
REQ-017 Read/Write asserted to Done asserted shall be WAIT_CYCLES+1 rising edges.
REQ-018 A read shall drive Mdatain with mem[latched address] from the RESP cycle onward.
REQ-019 Mdatain shall hold that read value until the next read's RESP cycle; writes shall not change Mdatain.
REQ-020 A write shall update mem[latched address] on the edge leaving RESP.
REQ-021 Read and Write both high in IDLE shall leave the FSM in IDLE, change no memory, and pulse Err for one cycle.
REQ-022 Address out of range (MAR[31:ADDR_BITS] nonzero) shall still take the full handshake with Done and Err both pulsed in RESP.
REQ-023 An out-of-range read shall return 32'h00000000; an out-of-range write shall be dropped.
REQ-024 Read or Write asserted in WAIT or RESP shall be ignored, with no queueing and no Err.
REQ-025 Requests are level-sampled, so a request still held in the IDLE cycle after RESP shall be accepted again as a new request.
REQ-026 Read-after-write to the same address shall return the written data.

Reset
REQ-027 clear=1 shall immediately force IDLE, Mdatain=0, Done=0, Busy=0, Err=0 and the wait counter to 0.
REQ-028 Reset asserted mid-operation shall abort it: a pending write shall not update memory and no Done shall be issued.
REQ-029 Memory contents shall not be cleared by reset.
REQ-030 The first request shall be accepted on the first rising edge after clear deasserts.

Structure
REQ-031 The shared package shall hold the FSM state encoding (2 bits), the default ADDR_BITS and WAIT_CYCLES, and the 32-bit data width constant.
REQ-032 Storage shall be one sub-module, ram_32 (synchronous write, combinational read, ADDR_BITS-parameterised), instantiated once.
REQ-033 The FSM, wait counter, request latches and Err/Done generation shall reside in mem_responder.

Verification
REQ-034 Write 32'h00000012 to address 5, then read address 5 (WAIT_CYCLES=1) -> Done 2 edges after each request; Mdatain=32'h00000012 in the read RESP cycle.
REQ-035 WAIT_CYCLES=0: read of preloaded address 3 holding 32'h00000014 -> Done on the next edge with Mdatain=32'h00000014; Busy high exactly 1 cycle.
REQ-036 Read and Write both high in IDLE -> Err pulse for 1 cycle, no Done, Busy stays 0, memory unchanged.
REQ-037 Read with MAR=32'h00000200 -> Done and Err pulse together, Mdatain=0; write to that address leaves all 512 words unchanged.
REQ-038 clear asserted mid-WAIT of a write of 32'h00000004 to address 7 -> outputs 0 immediately, no Done, and a later read of address 7 returns the old value.
REQ-039 Second Read asserted during WAIT -> ignored; exactly one Done, and Mdatain holds the first address's data.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared constants and FSM encoding for mem_responder
package mem_responder_pkg;

    localparam int DATA_W          = 32;
    localparam int DEF_ADDR_BITS   = 9;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_responder_ram_32.sv
// rtl/mem_responder_ram_32.sv - word storage, synchronous write, combinational read
module ram_32
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Contents deliberately have no reset so data survives a clear.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port commits on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request/Done memory responder with programmable wait states
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] MAR,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] MDRdata,
    output logic [DATA_W-1:0] Mdatain,
    output logic              Done,
    output logic              Busy,
    output logic              Err
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   is_write_q, is_write_d;
    logic                   oor_q, oor_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   req_one;
    logic                   req_both;
    logic                   mar_oor;
    logic [ADDR_BITS-1:0]   ram_addr;
    logic [DATA_W-1:0]      ram_rdata;
    logic                   ram_we;

    assign req_one  = Read ^ Write;
    assign req_both = Read & Write;
    assign mar_oor  = |(MAR >> ADDR_BITS);

    // In IDLE the RAM looks at the live MAR so a zero-wait read can be captured
    // on the accepting edge; otherwise it uses the latched address.
    assign ram_addr = (state_q == ST_IDLE) ? MAR[ADDR_BITS-1:0] : addr_q;
    assign ram_we   = (state_q == ST_RESP) && is_write_q && !oor_q;

    ram_32 #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Next-state, request latching, read capture and illegal-request detection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        oor_d      = oor_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_both) begin
                    err_d = 1'b1;
                end else if (req_one) begin
                    addr_d     = MAR[ADDR_BITS-1:0];
                    wdata_d    = MDRdata;
                    is_write_d = Write;
                    oor_d      = mar_oor;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        if (Read) begin
                            rdata_d = mar_oor ? '0 : ram_rdata;
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = ST_RESP;
                    if (!is_write_q) begin
                        rdata_d = oor_q ? '0 : ram_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers; clear aborts any transaction in flight.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            oor_q      <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            oor_q      <= oor_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign Mdatain = rdata_q;
    assign Done    = (state_q == ST_RESP);
    assign Busy    = (state_q != ST_IDLE);
    assign Err     = err_q | ((state_q == ST_RESP) && oor_q);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    localparam int WC    = 1;
    localparam int AB    = 9;
    localparam int DEPTH = 1 << AB;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;

    logic [31:0] mar = '0, wdat = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] Mdatain;
    logic        Done, Busy, Err;

    logic [31:0] mar0 = '0, wdat0 = '0;
    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] Mdatain0;
    logic        Done0, Busy0, Err0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rd = '0;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    always #5 Clock = ~Clock;

    mem_responder #(.WAIT_CYCLES(WC), .ADDR_BITS(AB)) dut (
        .Clock   (Clock),
        .clear   (clear),
        .MAR     (mar),
        .Read    (rd),
        .Write   (wr),
        .MDRdata (wdat),
        .Mdatain (Mdatain),
        .Done    (Done),
        .Busy    (Busy),
        .Err     (Err)
    );

    mem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(AB)) dut0 (
        .Clock   (Clock),
        .clear   (clear),
        .MAR     (mar0),
        .Read    (rd0),
        .Write   (wr0),
        .MDRdata (wdat0),
        .Mdatain (Mdatain0),
        .Done    (Done0),
        .Busy    (Busy0),
        .Err     (Err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic is_oor(input logic [31:0] a);
        return (a >> AB) != 32'd0;
    endfunction

    // One request on the WAIT_CYCLES=1 instance, with the expected Err/Mdatain at Done.
    task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        bit seen;
        rd = r; wr = w; mar = a; wdat = d;
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (lat == 1) begin
                rd = 1'b0; wr = 1'b0;
                chk("busy_after_accept", {31'd0, Busy}, 32'd1);
            end
            if (Done) seen = 1;
        end
        chk("done_latency", lat, WC + 1);
        chk("err_at_done", {31'd0, Err}, {31'd0, exp_err});
        chk("mdatain_at_done", Mdatain, exp_rd);
        tick();
        chk("idle_after_resp", {30'd0, Done, Busy}, 32'd0);
    endtask

    task automatic model_update(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (w && !is_oor(a)) mem_m[a[AB-1:0]] = d;
        if (r) last_rd = is_oor(a) ? 32'd0 : mem_m[a[AB-1:0]];
    endtask

    task automatic model_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e;
        e = r ? (is_oor(a) ? 32'd0 : mem_m[a[AB-1:0]]) : last_rd;
        txn(r, w, a, d, is_oor(a), e);
        model_update(r, w, a, d);
    endtask

    initial begin
        logic [4:0]  pat;
        int          ndone;
        logic        rr;
        logic [31:0] ra;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0012, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0012};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1, 32'h0000_0012};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0009, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0009, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b1, 32'h8000_0005, 32'h0000_0055, 1'b1, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0012};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_01FF, 32'hA5A5_A5A5, 1'b0, 32'h0000_0012};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_01FF, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};

        // Reset state of both instances.
        tick(); tick();
        chk("reset_outputs", {Mdatain[27:0], Done, Busy, Err, 1'b0}, 32'd0);
        chk("reset_mdatain", Mdatain, 32'd0);
        chk("reset_outputs0", {28'd0, Done0, Busy0, Err0, 1'b0}, 32'd0);
        clear = 1'b0;

        // Known contents everywhere so later sweeps can be compared.
        for (int i = 0; i < DEPTH; i++) model_txn(1'b0, 1'b1, i, $urandom);

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_err, vecs[i].exp_rd);
            model_update(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
        end

        // Read and Write together: Err pulse only, no handshake, no write.
        rd = 1'b1; wr = 1'b1; mar = 32'd5; wdat = 32'h99;
        tick();
        chk("both_err", {29'd0, Err, Busy, Done}, 32'd4);
        rd = 1'b0; wr = 1'b0;
        tick();
        chk("both_err_drop", {29'd0, Err, Busy, Done}, 32'd0);
        model_txn(1'b1, 1'b0, 32'd5, 32'd0);
        chk("both_mem_kept", last_rd, 32'h12);

        // A second read raised during WAIT is ignored.
        rd = 1'b1; mar = 32'd5;
        tick();
        mar = 32'd9;
        tick();
        chk("ignore_done", {31'd0, Done}, 32'd1);
        chk("ignore_data", Mdatain, mem_m[5]);
        chk("ignore_err", {31'd0, Err}, 32'd0);
        rd = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Done) ndone++;
        end
        chk("ignore_no_extra_done", ndone, 0);
        last_rd = mem_m[5];

        // A request still held after RESP is taken again.
        rd = 1'b1; mar = 32'd9;
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pat[i] = Done;
            if (i == 3) rd = 1'b0;
        end
        chk("reaccept_pattern", {27'd0, pat}, 32'b10010);
        chk("reaccept_data", Mdatain, mem_m[9]);
        tick();
        last_rd = mem_m[9];

        // clear during WAIT of a write aborts it; first request after clear is accepted.
        model_txn(1'b0, 1'b1, 32'd7, 32'h77);
        wr = 1'b1; mar = 32'd7; wdat = 32'h4;
        tick();
        wr = 1'b0;
        chk("abort_busy_before", {31'd0, Busy}, 32'd1);
        clear = 1'b1;
        #1;
        chk("abort_outputs", {29'd0, Done, Busy, Err}, 32'd0);
        chk("abort_mdatain", Mdatain, 32'd0);
        tick();
        chk("abort_no_done", {31'd0, Done}, 32'd0);
        clear = 1'b0;
        last_rd = 32'd0;
        model_txn(1'b1, 1'b0, 32'd7, 32'd0);
        chk("abort_old_value", last_rd, 32'h77);

        // Zero-wait instance: Done one edge after request, Busy for one cycle.
        wr0 = 1'b1; mar0 = 32'd3; wdat0 = 32'h14;
        tick();
        chk("w0_write_done", {30'd0, Done0, Busy0}, 32'd3);
        wr0 = 1'b0;
        tick();
        chk("w0_write_idle", {30'd0, Done0, Busy0}, 32'd0);
        rd0 = 1'b1; mar0 = 32'd3;
        tick();
        chk("w0_read_done", {30'd0, Done0, Busy0}, 32'd3);
        chk("w0_read_data", Mdatain0, 32'h14);
        rd0 = 1'b0;
        tick();
        chk("w0_read_idle", {29'd0, Done0, Busy0, Err0}, 32'd0);
        chk("w0_data_hold", Mdatain0, 32'h14);

        // Random traffic against the model, some of it out of range.
        for (int i = 0; i < 150; i++) begin
            rr = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
            model_txn(rr, !rr, ra, $urandom);
        end

        // Full sweep: out-of-range writes must not have touched any word.
        for (int i = 0; i < DEPTH; i++) model_txn(1'b1, 1'b0, i, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
